// File: rtl/filter_buffer_ctrl_if.sv
// filter_buffer_ctrl_if: loader handshake, buffer control and conv-engine
// handshake bundle for filter_buffer_ctrl.
// master = the sequencer side, slave = loader/buffer/conv-engine side.
interface filter_buffer_ctrl_if;
  // Loader stream handshake
  logic        in_valid;
  logic        in_ready;

  // Filter/bias buffer control
  logic        buf_read;
  logic        buf_bias_or_filter;
  logic [15:0] buf_index_buffer;
  logic [15:0] buf_index_bias;
  logic        buf_finish;

  // Conv engine handshake
  logic        next;
  logic        filter_valid;
  logic        done;

  modport master (
    input  in_valid,
    input  buf_finish,
    input  next,
    output in_ready,
    output buf_read,
    output buf_bias_or_filter,
    output buf_index_buffer,
    output buf_index_bias,
    output filter_valid,
    output done
  );

  modport slave (
    output in_valid,
    output buf_finish,
    output next,
    input  in_ready,
    input  buf_read,
    input  buf_bias_or_filter,
    input  buf_index_buffer,
    input  buf_index_bias,
    input  filter_valid,
    input  done
  );
endinterface

// File: rtl/filter_buffer_ctrl.sv
// filter_buffer_ctrl: sequencer for the 5x5 filter/bias buffer.
// Loads one bias vector followed by in_ch*out_ch filters from the loader
// stream, then serves filters in convolution order (input channel inner,
// output channel outer), one step per `next` pulse.
// Optional feature: define FBC_TIMEOUT_EN to bound the wait for buf_finish
// to TIMEOUT cycles, after which err is raised and the load is abandoned.
module filter_buffer_ctrl #(
  parameter int unsigned NUM_FILTERS = 1920,
  parameter int unsigned NUM_BIAS    = 120,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          cfg_in_ch,
  input  logic [7:0]          cfg_out_ch,
  output logic                err,
  filter_buffer_ctrl_if.master bus
);

  localparam int unsigned CH_W  = 8;
  localparam int unsigned IDX_W = 16;
  localparam logic [IDX_W-1:0] MAX_FILTERS = IDX_W'(NUM_FILTERS);
  localparam logic [IDX_W-1:0] MAX_BIAS    = IDX_W'(NUM_BIAS);

  // Parameter sanity: depths must fit the 16-bit indices / 8-bit channel counts
  if (NUM_FILTERS == 0 || NUM_FILTERS > 65535 || NUM_BIAS == 0 || NUM_BIAS > 255 ||
      TIMEOUT == 0) begin : g_param_check
    $error("filter_buffer_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_STROBE,
    S_HOLD,
    S_DROP,
    S_SERVE
  } state_t;

  state_t           state;
  logic             phase_filter;
  logic [CH_W-1:0]  in_ch;
  logic [CH_W-1:0]  out_ch;
  logic [CH_W-1:0]  ic;
  logic [CH_W-1:0]  oc;
  logic [IDX_W-1:0] fidx;
  logic [IDX_W-1:0] last_idx;

  logic             buf_read;
  logic             in_ready;
  logic             bias_or_filter;
  logic [IDX_W-1:0] index_buffer;
  logic [IDX_W-1:0] index_bias;
  logic             filter_valid;
  logic             done;

`ifdef FBC_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
  logic [HOLD_W-1:0] hold_cnt;
`endif

  logic [IDX_W-1:0] cfg_prod_c;
  logic             cfg_bad_c;
  logic             in_last_c;
  logic             out_last_c;

  // Configuration check at start: total filters and bias count must fit the buffer
  assign cfg_prod_c = IDX_W'(cfg_in_ch) * IDX_W'(cfg_out_ch);
  assign cfg_bad_c  = (cfg_in_ch == '0) || (cfg_out_ch == '0) ||
                      (IDX_W'(cfg_out_ch) > MAX_BIAS) || (cfg_prod_c > MAX_FILTERS);

  // Serve-order wrap detection for the channel counters
  assign in_last_c  = (ic == (in_ch - CH_W'(1)));
  assign out_last_c = (oc == (out_ch - CH_W'(1)));

  // Sequencer: state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      phase_filter   <= 1'b0;
      in_ch          <= '0;
      out_ch         <= '0;
      ic             <= '0;
      oc             <= '0;
      fidx           <= '0;
      last_idx       <= '0;
      buf_read       <= 1'b0;
      in_ready       <= 1'b0;
      bias_or_filter <= 1'b0;
      index_buffer   <= '0;
      index_bias     <= '0;
      filter_valid   <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef FBC_TIMEOUT_EN
      hold_cnt       <= '0;
`endif
    end else begin
      in_ready <= 1'b0;
      done     <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad_c) begin
              err <= 1'b1;
            end else begin
              err            <= 1'b0;
              in_ch          <= cfg_in_ch;
              out_ch         <= cfg_out_ch;
              last_idx       <= cfg_prod_c - IDX_W'(1);
              ic             <= '0;
              oc             <= '0;
              fidx           <= '0;
              phase_filter   <= 1'b0;
              bias_or_filter <= 1'b0;
              index_buffer   <= '0;
              index_bias     <= '0;
              state          <= S_WAIT_IN;
            end
          end
        end

        S_WAIT_IN: begin
          if (bus.in_valid) begin
            buf_read <= 1'b1;
            state    <= S_STROBE;
          end
        end

        // Bias writes complete in one strobe; filter writes wait for buf_finish
        S_STROBE: begin
          if (phase_filter) begin
            state <= S_HOLD;
`ifdef FBC_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            buf_read <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_DROP;
          end
        end

        S_HOLD: begin
          if (bus.buf_finish) begin
            buf_read <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_DROP;
          end
`ifdef FBC_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST) begin
            err      <= 1'b1;
            buf_read <= 1'b0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
`endif
        end

        S_DROP: begin
          if (!phase_filter) begin
            phase_filter   <= 1'b1;
            bias_or_filter <= 1'b1;
            state          <= S_WAIT_IN;
          end else if (fidx == last_idx) begin
            fidx         <= '0;
            ic           <= '0;
            oc           <= '0;
            index_buffer <= '0;
            index_bias   <= '0;
            filter_valid <= 1'b1;
            state        <= S_SERVE;
          end else begin
            fidx         <= fidx + IDX_W'(1);
            index_buffer <= fidx + IDX_W'(1);
            state        <= S_WAIT_IN;
          end
        end

        // Filter index runs as an accumulator; bias index follows oc
        S_SERVE: begin
          if (bus.next) begin
            if (in_last_c) begin
              ic <= '0;
              if (out_last_c) begin
                done         <= 1'b1;
                filter_valid <= 1'b0;
                index_buffer <= '0;
                index_bias   <= '0;
                state        <= S_IDLE;
              end else begin
                oc           <= oc + CH_W'(1);
                index_bias   <= IDX_W'(oc) + IDX_W'(1);
                index_buffer <= index_buffer + IDX_W'(1);
              end
            end else begin
              ic           <= ic + CH_W'(1);
              index_buffer <= index_buffer + IDX_W'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Drive the interface from the registered outputs
  assign bus.in_ready           = in_ready;
  assign bus.buf_read           = buf_read;
  assign bus.buf_bias_or_filter = bias_or_filter;
  assign bus.buf_index_buffer   = index_buffer;
  assign bus.buf_index_bias     = index_bias;
  assign bus.filter_valid       = filter_valid;
  assign bus.done               = done;

endmodule
